// File: rtl/ahb_arbiter_param.sv
// AHB bus arbiter with programmable master count, per-master priority and fixed or round-robin tie-breaking.
// Re-arbitration is burst-aware, respects HLOCK and caps undefined-length INCR bursts at MaxHold beats.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | owner issues IDLE or has no burst in flight
// ST_BURST    | fixed-length or INCR burst in flight
// ST_LOCKED   | owner holds hlock together with hbusreq
// ST_HANDOVER | grant moved to a new master, waiting for hready to move hmaster
module ahb_arbiter_param #(
   parameter int MasNum    = 4,
   parameter int PrioWidth = 2,
   parameter int RrMode    = 1,
   parameter int DefMas    = 0,
   parameter int MaxHold   = 16
) (
   input  logic                        hclk,
   input  logic                        hreset,
   input  logic [MasNum-1:0]           hbusreq,
   input  logic [MasNum-1:0]           hlock,
   input  logic [MasNum*PrioWidth-1:0] hprior,
   input  logic [1:0]                  htrans,
   input  logic [2:0]                  hburst,
   input  logic                        hready,
   output logic [MasNum-1:0]           hgrant,
   output logic [$clog2(MasNum)-1:0]   hmaster,
   output logic [$clog2(MasNum)-1:0]   hmaster_d,
   output logic                        hmastlock
);

   localparam int IdxW = $clog2(MasNum);
   localparam int CntW = 8;

   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_NONSEQ = 2'd2;

   localparam logic [2:0] HB_SINGLE = 3'd0;
   localparam logic [2:0] HB_INCR   = 3'd1;
   localparam logic [2:0] HB_WRAP4  = 3'd2;
   localparam logic [2:0] HB_INCR4  = 3'd3;
   localparam logic [2:0] HB_WRAP8  = 3'd4;
   localparam logic [2:0] HB_INCR8  = 3'd5;

   typedef logic [IdxW-1:0] idx_t;
   typedef logic [CntW-1:0] cnt_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_BURST    = 2'd1,
      ST_LOCKED   = 2'd2,
      ST_HANDOVER = 2'd3
   } state_t;

   if (DefMas < 0 || DefMas >= MasNum) begin : g_bad_defmas
      $error("ahb_arbiter_param: DefMas must be in 0..MasNum-1");
   end
   if (MasNum < 2 || MasNum > 16) begin : g_bad_masnum
      $error("ahb_arbiter_param: MasNum must be in 2..16");
   end
   if (MaxHold < 1 || MaxHold > 255) begin : g_bad_maxhold
      $error("ahb_arbiter_param: MaxHold must be in 1..255");
   end

   state_t state_q, state_d;
   idx_t   grant_q, grant_d;
   idx_t   mas_addr_q, mas_addr_d;
   idx_t   mas_data_q, mas_data_d;
   idx_t   rr_q, rr_d;
   logic   lock_q, lock_d;
   cnt_t   cnt_q, cnt_d;

   logic                 win_found;
   idx_t                 win_idx;
   logic [PrioWidth-1:0] win_pri;
   logic [PrioWidth-1:0] scan_pri;
   idx_t                 scan_idx;
   int                   scan_sum;

   cnt_t burst_len;
   cnt_t cnt_eff;
   logic is_beat;
   logic last_beat;
   logic owner_req;
   logic owner_lock;
   logic decide;

   // Scan order starts just after the rr pointer in round-robin mode, at index 0 otherwise;
   // a strict greater-than keeps the first tied master found.
   always_comb begin
      win_found = 1'b0;
      win_idx   = idx_t'(DefMas);
      win_pri   = '0;
      scan_sum  = 0;
      scan_idx  = '0;
      scan_pri  = '0;
      for (int k = 0; k < MasNum; k++) begin
         if (RrMode != 0) begin
            scan_sum = int'(rr_q) + 1 + k;
            if (scan_sum >= MasNum) begin
               scan_sum = scan_sum - MasNum;
            end
         end else begin
            scan_sum = k;
         end
         scan_idx = idx_t'(scan_sum);
         scan_pri = hprior[scan_sum*PrioWidth +: PrioWidth];
         if (hbusreq[scan_idx] && (!win_found || scan_pri > win_pri)) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
            win_pri   = scan_pri;
         end
      end
   end

   always_comb begin
      case (hburst)
         HB_SINGLE:          burst_len = cnt_t'(1);
         HB_INCR:            burst_len = cnt_t'(MaxHold);
         HB_WRAP4, HB_INCR4: burst_len = cnt_t'(4);
         HB_WRAP8, HB_INCR8: burst_len = cnt_t'(8);
         default:            burst_len = cnt_t'(16);
      endcase
   end

   // cnt_eff is the number of beats left including the one now in the address phase.
   assign cnt_eff    = (htrans == TR_NONSEQ) ? burst_len : cnt_q;
   assign is_beat    = htrans[1];
   assign last_beat  = is_beat && (cnt_eff == cnt_t'(1));
   assign owner_req  = hbusreq[mas_addr_q];
   assign owner_lock = hlock[mas_addr_q] & owner_req;
   assign decide     = hready && (state_q != ST_HANDOVER) && !owner_lock &&
                       ((htrans == TR_IDLE) || last_beat || !owner_req);

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q    <= ST_IDLE;
         grant_q    <= idx_t'(DefMas);
         mas_addr_q <= idx_t'(DefMas);
         mas_data_q <= idx_t'(DefMas);
         rr_q       <= idx_t'(DefMas);
         lock_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         mas_addr_q <= mas_addr_d;
         mas_data_q <= mas_data_d;
         rr_q       <= rr_d;
         lock_q     <= lock_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (hready) begin
         if (state_q == ST_HANDOVER) begin
            state_d = ST_IDLE;
         end else if (decide && (win_idx != grant_q)) begin
            state_d = ST_HANDOVER;
         end else if (owner_lock) begin
            state_d = ST_LOCKED;
         end else if ((htrans != TR_IDLE) && !last_beat) begin
            state_d = ST_BURST;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   always_comb begin
      grant_d    = grant_q;
      mas_addr_d = mas_addr_q;
      mas_data_d = mas_data_q;
      rr_d       = rr_q;
      lock_d     = lock_q;
      cnt_d      = cnt_q;
      if (hready) begin
         mas_data_d = mas_addr_q;
         if (state_q == ST_HANDOVER) begin
            mas_addr_d = grant_q;
         end
         lock_d = hlock[mas_addr_d];
         if (decide) begin
            grant_d = win_idx;
            if (win_found) begin
               rr_d = win_idx;
            end
         end
         // An exhausted INCR reloads so a locked or re-granted owner keeps a valid count.
         if (is_beat) begin
            if (cnt_eff > cnt_t'(1)) begin
               cnt_d = cnt_eff - cnt_t'(1);
            end else if ((cnt_eff == cnt_t'(1)) && (hburst == HB_INCR)) begin
               cnt_d = cnt_t'(MaxHold);
            end else begin
               cnt_d = '0;
            end
         end
      end
   end

   assign hgrant    = {{(MasNum-1){1'b0}}, 1'b1} << grant_q;
   assign hmaster   = mas_addr_q;
   assign hmaster_d = mas_data_q;
   assign hmastlock = lock_q;

endmodule

// File: tb/tb_ahb_arbiter_param.sv
// Directed bench for ahb_arbiter_param: a round-robin and a fixed-priority instance share stimulus;
// the fixed instance is only compared where its behaviour is defined by that stimulus.
module tb_ahb_arbiter_param;

   logic       hclk = 1'b0;
   logic       hreset;
   logic [3:0] hbusreq;
   logic [3:0] hlock;
   logic [7:0] hprior;
   logic [1:0] htrans;
   logic [2:0] hburst;
   logic       hready;

   logic [3:0] rr_hgrant, fx_hgrant;
   logic [1:0] rr_hmaster, rr_hmaster_d, fx_hmaster, fx_hmaster_d;
   logic       rr_hmastlock, fx_hmastlock;

   int n_chk = 0;
   int n_bad = 0;
   int changes;
   int prev;
   int order [5] = '{1, 2, 3, 0, 1};

   always #5 hclk = ~hclk;

   ahb_arbiter_param #(.MasNum(4), .PrioWidth(2), .RrMode(1), .DefMas(0), .MaxHold(16)) u_rr (
      .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock), .hprior(hprior),
      .htrans(htrans), .hburst(hburst), .hready(hready),
      .hgrant(rr_hgrant), .hmaster(rr_hmaster), .hmaster_d(rr_hmaster_d), .hmastlock(rr_hmastlock)
   );

   ahb_arbiter_param #(.MasNum(4), .PrioWidth(2), .RrMode(0), .DefMas(0), .MaxHold(16)) u_fix (
      .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock), .hprior(hprior),
      .htrans(htrans), .hburst(hburst), .hready(hready),
      .hgrant(fx_hgrant), .hmaster(fx_hmaster), .hmaster_d(fx_hmaster_d), .hmastlock(fx_hmastlock)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic do_reset();
      hreset  = 1'b1;
      hbusreq = 4'b0000;
      hlock   = 4'b0000;
      htrans  = 2'd0;
      hburst  = 3'd0;
      hready  = 1'b1;
      step();
      hreset  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      hprior = 8'h00;
      do_reset();
      chk("rst_grant",    rr_hgrant,    32'h1);
      chk("rst_master",   rr_hmaster,   32'h0);
      chk("rst_master_d", rr_hmaster_d, 32'h0);
      chk("rst_lock",     rr_hmastlock, 32'h0);
      chk("rst_fx_lock",  fx_hmastlock, 32'h0);
      repeat (10) step();
      chk("idle_grant",    rr_hgrant, 32'h1);
      chk("idle_fx_grant", fx_hgrant, 32'h1);

      // m3..m0 priorities 3,1,3,0: fixed picks m1, round-robin alternates m1 then m3
      hprior  = {2'd3, 2'd1, 2'd3, 2'd0};
      hbusreq = 4'b1111;
      step();
      chk("fp_rr_grant", rr_hgrant, 32'h2);
      chk("fp_fx_grant", fx_hgrant, 32'h2);
      step();
      chk("fp_fx_master",   fx_hmaster,   32'h1);
      chk("fp_rr_master",   rr_hmaster,   32'h1);
      chk("fp_rr_master_d", rr_hmaster_d, 32'h0);
      htrans = 2'd2;
      hburst = 3'd0;
      step();
      chk("fp_rr_grant2", rr_hgrant, 32'h8);
      chk("fp_fx_grant2", fx_hgrant, 32'h2);

      // round-robin with equal priorities and back-to-back SINGLE transfers
      do_reset();
      hprior  = 8'hAA;
      hbusreq = 4'b1111;
      htrans  = 2'd2;
      hburst  = 3'd0;
      prev    = 0;
      for (int j = 0; j < 5; j++) begin
         step();
         chk("rr_grant", rr_hgrant, 32'd1 << order[j]);
         step();
         chk("rr_master",   rr_hmaster,   order[j]);
         chk("rr_master_d", rr_hmaster_d, prev);
         prev = order[j];
      end

      // m2 INCR8, m3 higher priority from beat 3, two wait states after beat 4
      do_reset();
      hprior  = {2'd3, 2'd1, 2'd0, 2'd0};
      hbusreq = 4'b0100;
      step();
      chk("b8_grant_m2", rr_hgrant, 32'h4);
      step();
      chk("b8_master_m2", rr_hmaster, 32'h2);
      htrans = 2'd2;
      hburst = 3'd5;
      step();
      htrans = 2'd3;
      step();
      hbusreq = 4'b1100;
      step();
      chk("b8_beat3", rr_hgrant, 32'h4);
      step();
      hready = 1'b0;
      step();
      step();
      chk("b8_stall_grant",    rr_hgrant,    32'h4);
      chk("b8_stall_master_d", rr_hmaster_d, 32'h2);
      hready = 1'b1;
      repeat (3) step();
      chk("b8_beat7", rr_hgrant, 32'h4);
      step();
      chk("b8_beat8", rr_hgrant, 32'h8);
      htrans = 2'd0;
      step();
      chk("b8_master_m3", rr_hmaster, 32'h3);

      // m1 locked INCR for 40 beats while m0 requests
      do_reset();
      hprior  = 8'hAA;
      hbusreq = 4'b0011;
      hlock   = 4'b0010;
      step();
      chk("lk_grant_m1", rr_hgrant, 32'h2);
      step();
      chk("lk_master", rr_hmaster,   32'h1);
      chk("lk_lock",   rr_hmastlock, 32'h1);
      htrans  = 2'd2;
      hburst  = 3'd1;
      changes = 0;
      for (int b = 1; b <= 40; b++) begin
         step();
         if (rr_hgrant !== 4'b0010) changes++;
         htrans = 2'd3;
      end
      chk("lk_hold",      changes,      32'h0);
      chk("lk_lock_40",   rr_hmastlock, 32'h1);
      hbusreq = 4'b0001;
      hlock   = 4'b0000;
      htrans  = 2'd0;
      step();
      chk("lk_release_grant", rr_hgrant,    32'h1);
      chk("lk_release_lock",  rr_hmastlock, 32'h0);
      step();
      chk("lk_release_master", rr_hmaster, 32'h0);

      // same burst unlocked: forced re-arbitration after beat 16
      hbusreq = 4'b0010;
      step();
      chk("ul_grant_m1", rr_hgrant, 32'h2);
      step();
      hbusreq = 4'b0011;
      htrans  = 2'd2;
      hburst  = 3'd1;
      changes = 0;
      for (int b = 1; b <= 15; b++) begin
         step();
         if (rr_hgrant !== 4'b0010) changes++;
         htrans = 2'd3;
      end
      chk("ul_hold", changes, 32'h0);
      step();
      chk("ul_switch", rr_hgrant, 32'h1);

      // reset in beat 2 of a locked WRAP4 owned by m3
      do_reset();
      hprior  = 8'hAA;
      hbusreq = 4'b1000;
      hlock   = 4'b1000;
      step();
      chk("wr_grant_m3", rr_hgrant, 32'h8);
      step();
      htrans = 2'd2;
      hburst = 3'd2;
      step();
      chk("wr_master_d", rr_hmaster_d, 32'h3);
      chk("wr_lock",     rr_hmastlock, 32'h1);
      htrans = 2'd3;
      hreset = 1'b1;
      step();
      chk("mr_grant",    rr_hgrant,    32'h1);
      chk("mr_master",   rr_hmaster,   32'h0);
      chk("mr_master_d", rr_hmaster_d, 32'h0);
      chk("mr_lock",     rr_hmastlock, 32'h0);
      chk("mr_cnt",      u_rr.cnt_q,   32'h0);
      hreset = 1'b0;
      htrans = 2'd0;
      step();
      chk("mr_regrant", rr_hgrant, 32'h8);
      step();
      chk("mr_remaster", rr_hmaster, 32'h3);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/ahb_arbiter_param.md
Name: ahb_arbiter_param

Overview:
- Parametrised AHB bus arbiter, next generation of the fixed 4-master arbitration inside the AHB bus fabric.
- Supports any master count, per-master programmable priority, and selectable fixed-priority or round-robin tie-breaking.
- Adds burst-aware re-arbitration, HLOCK handling and a bounded hold time for undefined-length INCR bursts.
- Sits between the master interfaces and the address/write-data muxes; drives grant, master index and mastlock.

Parameters:
- MasNum, 4, number of masters (2..16).
- PrioWidth, 2, width of each master's priority field; larger value = higher priority.
- RrMode, 1, 0 = fixed priority (ties go to lowest index); 1 = round-robin among tied masters.
- DefMas, 0, default master index, granted when no master requests.
- MaxHold, 16, max beats of an INCR burst before forced re-arbitration (1..255).

Ports:
- hclk  input  1  bus clock; all logic on rising edge.
- hreset  input  1  synchronous, active-high reset.
- hbusreq  input  MasNum  bus request, one bit per master.
- hlock  input  MasNum  locked-transfer request, one bit per master.
- hprior  input  MasNum*PrioWidth  per-master priority; master i uses bits [i*PrioWidth +: PrioWidth].
- htrans  input  2  transfer type of the current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hburst  input  3  burst type of the current owner (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
- hready  input  1  bus ready from the slave mux.
- hgrant  output  MasNum  one-hot grant.
- hmaster  output  $clog2(MasNum)  address-phase owner index.
- hmaster_d  output  $clog2(MasNum)  data-phase owner index.
- hmastlock  output  1  current address phase is locked.

Behaviour:
- Decided: one clock; reset is synchronous and active-high.
- Reset, applied on any edge with hreset=1 (including mid-burst): hgrant = one-hot DefMas, hmaster = DefMas, hmaster_d = DefMas, hmastlock = 0. Beat counter = 0, FSM = IDLE, rr pointer = DefMas.
- FSM states:
  - IDLE: owner issues IDLE or no request.
  - BURST: fixed-length or INCR burst in flight.
  - LOCKED: owner holds hlock.
  - HANDOVER: grant changed; waiting for hready to move hmaster.
- Beat counter:
  - Loads on NONSEQ accepted (htrans=2 and hready=1): SINGLE->1, *4->4, *8->8, *16->16, INCR->MaxHold.
  - Decrements on each SEQ accepted.
  - Counter == 1 with hready=1 marks the last beat.
  - BUSY beats do not decrement.
- Decision point: an edge with hready=1 and any of the following:
  - state IDLE;
  - last beat of a fixed burst;
  - INCR count exhausted;
  - owner's hbusreq=0 while not locked.
- No decision is taken while the owner has hlock=1 and hbusreq=1 (LOCKED), regardless of beat count.
- Arbitration at a decision point: candidates = masters with hbusreq=1; winner = highest priority value.
  - Ties with RrMode=0: lowest index wins.
  - Ties with RrMode=1: first index strictly after the rr pointer, wrapping MasNum-1 -> 0.
  - rr pointer updates to the winner when a grant is issued.
  - No candidates: winner = DefMas.
- hgrant is registered: the winner appears one cycle after the decision edge. If the winner equals the current owner, no HANDOVER occurs.
- hmaster loads the granted index on the first subsequent edge with hready=1 (HANDOVER -> IDLE/BURST). hmastlock loads hlock[granted] on the same edge.
- hmaster_d <= hmaster on every edge with hready=1; it holds while hready=0.
- hready=0: all state, counter, grant and outputs hold.
- hprior changes take effect only at the next decision point.
- Out-of-range DefMas is a configuration error; the RTL elaborates with an assertion.

Test Plan:
- Reset with MasNum=4, DefMas=0, no requests -> hgrant=4'b0001, hmaster=0, hmastlock=0; still 0001 after 10 idle cycles.
- Fixed priority, RrMode=0, hprior={3,1,3,0} (m3..m0), hbusreq=4'b1111, all SINGLE -> winner m1, since tied priority-3 masters go to the lowest index; hmaster=1 after handover.
- Round-robin, all hprior=2, hbusreq=4'b1111, SINGLE transfers, hready=1 -> grant order 1,2,3,0,1; hmaster_d lags hmaster by one hready cycle.
- m2 owns an INCR8 burst; m3 raises a higher-priority request at beat 3 -> hgrant stays 0100 until the edge of beat 8, then 1000; insert hready=0 for 2 cycles mid-burst -> completion delayed exactly 2 cycles.
- m1 with hlock=1 runs INCR for 40 beats, MaxHold=16, m0 requesting -> no grant change during the 40 beats; hmastlock=1. After m1 drops hlock and hbusreq -> grant to m0. Repeat unlocked -> forced switch after beat 16.
- Assert hreset during a WRAP4 beat 2 owned by m3 -> next cycle hgrant=0001, hmaster=0, hmaster_d=0, counter cleared; normal arbitration on release.
